// File: rtl/hilo_div_unit.sv
// Iterative radix-2 restoring divider for div/divu. Quotient goes to LO, remainder to HI.
// One quotient bit per cycle. A divisor of zero short-circuits to a single-cycle result.
module hilo_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       i_divide,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_by_zero
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e           r_state,     w_state;
    logic [CntW-1:0]  r_cnt,       w_cnt;
    logic [WIDTH-1:0] r_rem,       w_rem;
    logic [WIDTH-1:0] r_quo,       w_quo;
    logic [WIDTH-1:0] r_dvs,       w_dvs;
    logic             r_q_neg,     w_q_neg;
    logic             r_r_neg,     w_r_neg;
    logic             r_zero,      w_zero;
    logic [WIDTH-1:0] r_quotient,  w_quotient;
    logic [WIDTH-1:0] r_remainder, w_remainder;
    logic             r_done,      w_done;
    logic             r_dbz,       w_dbz;

    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_trial;

    always_comb begin
        w_signed = i_divide[0];
        w_a_neg  = w_signed & i_dividend[WIDTH-1];
        w_b_neg  = w_signed & i_divisor[WIDTH-1];
        w_a_mag  = w_a_neg ? (~i_dividend + 1'b1) : i_dividend;
        w_b_mag  = w_b_neg ? (~i_divisor + 1'b1) : i_divisor;
        // Shifted partial remainder keeps its carry-out bit so divisors >= 2^(WIDTH-1) work.
        w_trial  = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_dvs};
    end

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_rem       = r_rem;
        w_quo       = r_quo;
        w_dvs       = r_dvs;
        w_q_neg     = r_q_neg;
        w_r_neg     = r_r_neg;
        w_zero      = r_zero;
        w_quotient  = r_quotient;
        w_remainder = r_remainder;
        w_dbz       = r_dbz;
        w_done      = 1'b0;

        if (i_flush) begin
            w_state = StIdle;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_divide[1]) begin
                        if (i_divisor == '0) begin
                            w_state = StFix;
                            w_zero  = 1'b1;
                            w_rem   = i_dividend;
                        end else begin
                            w_state = StCalc;
                            w_zero  = 1'b0;
                            w_rem   = '0;
                            w_quo   = w_a_mag;
                            w_dvs   = w_b_mag;
                            w_q_neg = w_a_neg ^ w_b_neg;
                            w_r_neg = w_a_neg;
                            w_cnt   = CntW'(WIDTH - 1);
                            w_dbz   = 1'b0;
                        end
                    end
                end
                StCalc: begin
                    w_quo = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
                    w_rem = w_trial[WIDTH] ? {r_rem[WIDTH-2:0], r_quo[WIDTH-1]}
                                           : w_trial[WIDTH-1:0];
                    if (r_cnt == '0) begin
                        w_state = StFix;
                    end else begin
                        w_cnt = r_cnt - 1'b1;
                    end
                end
                StFix: begin
                    w_state = StIdle;
                    w_done  = 1'b1;
                    if (r_zero) begin
                        w_quotient  = '1;
                        w_remainder = r_rem;
                        w_dbz       = 1'b1;
                    end else begin
                        w_quotient  = r_q_neg ? (~r_quo + 1'b1) : r_quo;
                        w_remainder = r_r_neg ? (~r_rem + 1'b1) : r_rem;
                    end
                end
                default: w_state = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_zero      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_rem       <= w_rem;
            r_quo       <= w_quo;
            r_dvs       <= w_dvs;
            r_q_neg     <= w_q_neg;
            r_r_neg     <= w_r_neg;
            r_zero      <= w_zero;
            r_quotient  <= w_quotient;
            r_remainder <= w_remainder;
            r_done      <= w_done;
            r_dbz       <= w_dbz;
        end
    end

    assign o_quotient    = r_quotient;
    assign o_remainder   = r_remainder;
    assign o_busy        = (r_state != StIdle);
    assign o_done        = r_done;
    assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_hilo_div_unit.sv
// Directed bench for hilo_div_unit: results, latency, zero divide, flush and async reset.
module tb_hilo_div_unit;

    logic        clk;
    logic        rst_n;
    logic [1:0]  i_divide;
    logic        i_flush;
    logic [31:0] i_dividend;
    logic [31:0] i_divisor;
    logic [31:0] o_quotient;
    logic [31:0] o_remainder;
    logic        o_busy;
    logic        o_done;
    logic        o_div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;

    hilo_div_unit #(.WIDTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_divide      (i_divide),
        .i_flush       (i_flush),
        .i_dividend    (i_dividend),
        .i_divisor     (i_divisor),
        .o_quotient    (o_quotient),
        .o_remainder   (o_remainder),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_div_by_zero (o_div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (o_done) n_done++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic run_div(input string tag, input logic [1:0] code,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er,
                           input logic edbz, input int elat);
        int   lat;
        logic busy_gap;
        @(negedge clk);
        i_divide   = code;
        i_dividend = a;
        i_divisor  = b;
        @(posedge clk);
        #1;
        i_divide = 2'b00;
        lat      = 0;
        busy_gap = 1'b0;
        while (lat < 100) begin
            if (lat > 0 && !o_busy) busy_gap = 1'b1;
            @(posedge clk);
            #1;
            lat++;
            if (o_done) break;
        end
        check({tag, " latency"}, lat, elat);
        check({tag, " busy_gap"}, {31'b0, busy_gap}, 32'd0);
        check({tag, " busy_in_done"}, {31'b0, o_busy}, 32'd0);
        check({tag, " quotient"}, o_quotient, eq);
        check({tag, " remainder"}, o_remainder, er);
        check({tag, " dbz"}, {31'b0, o_div_by_zero}, {31'b0, edbz});
        @(posedge clk);
        #1;
        check({tag, " done_one_cycle"}, {31'b0, o_done}, 32'd0);
    endtask

    initial begin
        int snap;
        rst_n      = 1'b0;
        i_divide   = 2'b00;
        i_flush    = 1'b0;
        i_dividend = '0;
        i_divisor  = '0;
        #1;
        check("reset quotient", o_quotient, 32'd0);
        check("reset remainder", o_remainder, 32'd0);
        check("reset flags", {29'b0, o_busy, o_done, o_div_by_zero}, 32'd0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        run_div("divu 100/7", 2'b10, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
        run_div("div -7/2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
        run_div("divu max/16", 2'b10, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0, 33);
        run_div("div ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33);
        run_div("div 7/-2", 2'b11, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 33);
        run_div("divu bigdiv", 2'b10, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE,
                1'b0, 33);
        run_div("divu x/0", 2'b10, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1);
        run_div("divu 9/3", 2'b10, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);

        // Flush mid-operation; an overlapping start while busy must be ignored.
        snap = n_done;
        @(negedge clk);
        i_divide   = 2'b10;
        i_dividend = 32'd100;
        i_divisor  = 32'd7;
        @(posedge clk);
        #1;
        i_divide = 2'b00;
        repeat (9) @(posedge clk);
        @(negedge clk);
        i_divide   = 2'b10;
        i_dividend = 32'd50;
        i_divisor  = 32'd5;
        @(posedge clk);
        #1;
        i_divide = 2'b00;
        check("flush busy_mid", {31'b0, o_busy}, 32'd1);
        repeat (9) @(posedge clk);
        @(negedge clk);
        i_flush = 1'b1;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        check("flush busy_after", {31'b0, o_busy}, 32'd0);
        check("flush quotient_kept", o_quotient, 32'd3);
        check("flush remainder_kept", o_remainder, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check("flush no_done", n_done - snap, 32'd0);
        check("flush stays_idle", {31'b0, o_busy}, 32'd0);
        run_div("divu 50/5", 2'b10, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 33);

        // Asynchronous reset in the middle of CALC.
        snap = n_done;
        @(negedge clk);
        i_divide   = 2'b10;
        i_dividend = 32'd100;
        i_divisor  = 32'd7;
        @(posedge clk);
        #1;
        i_divide = 2'b00;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst quotient", o_quotient, 32'd0);
        check("arst remainder", o_remainder, 32'd0);
        check("arst flags", {29'b0, o_busy, o_done, o_div_by_zero}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("arst no_done", n_done - snap, 32'd0);
        run_div("divu 20/6", 2'b10, 32'd20, 32'd6, 32'd3, 32'd2, 1'b0, 33);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
